// File: rtl/ccu_pkg.sv
// Shared definitions for the coincidence-count output path: sequencer state
// encoding, default packet count and a mask-scan helper.
package ccu_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  localparam int NUM_PACKETS_DEFAULT = 10;

  // True when any bit of mask lies strictly above idx; masks are zero-extended to 64 bits.
  function automatic logic any_above(input logic [63:0] mask, input logic [6:0] idx);
    logic [63:0] shifted;
    shifted = mask >> (idx + 7'd1);
    return |shifted;
  endfunction

endpackage

// File: rtl/first_set_above.sv
// Finds the lowest set bit of mask, either anywhere (from_zero) or strictly
// above index. Purely combinational.
module first_set_above
  import ccu_pkg::*;
#(
  parameter int NUM_PACKETS = NUM_PACKETS_DEFAULT,
  localparam int SEL_W = $clog2(NUM_PACKETS)
) (
  input  logic [NUM_PACKETS-1:0] mask,
  input  logic [SEL_W-1:0]       index,
  input  logic                   from_zero,
  output logic [SEL_W-1:0]       next_index,
  output logic                   found
);

  // Scan downward so the lowest qualifying bit is the final assignment.
  always_comb begin
    next_index = '0;
    found      = 1'b0;
    for (int i = NUM_PACKETS - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || (i > int'(index)))) begin
        next_index = SEL_W'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_sequencer.sv
// Steps the packet mux select across the enabled coincidence-count packets and
// hands each one to the transmitter under a valid/ready handshake.
module output_sequencer
  import ccu_pkg::*;
#(
  parameter int NUM_PACKETS = NUM_PACKETS_DEFAULT,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(NUM_PACKETS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [NUM_PACKETS-1:0] chan_mask,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       selection,
  output logic                   last,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       frame_count
);

  state_t                 state_q, state_d;
  logic [NUM_PACKETS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]       sel_d;
  logic                   valid_d, last_d, busy_d, done_d;
  logic [CNT_W-1:0]       count_d;

  logic [SEL_W-1:0]       first_idx, adv_idx;
  logic                   first_found, adv_found;
  logic                   first_last, adv_last;
  logic [63:0]            chan_ext, mask_ext;

  first_set_above #(.NUM_PACKETS(NUM_PACKETS)) u_first (
    .mask       (chan_mask),
    .index      ('0),
    .from_zero  (1'b1),
    .next_index (first_idx),
    .found      (first_found)
  );

  first_set_above #(.NUM_PACKETS(NUM_PACKETS)) u_advance (
    .mask       (mask_q),
    .index      (selection),
    .from_zero  (1'b0),
    .next_index (adv_idx),
    .found      (adv_found)
  );

  // last is registered, so it is precomputed for whichever packet is loaded next.
  always_comb begin
    chan_ext = '0;
    mask_ext = '0;
    chan_ext[NUM_PACKETS-1:0] = chan_mask;
    mask_ext[NUM_PACKETS-1:0] = mask_q;
    first_last = !any_above(chan_ext, 7'(first_idx));
    adv_last   = !any_above(mask_ext, 7'(adv_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      selection   <= '0;
      out_valid   <= 1'b0;
      last        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      selection   <= sel_d;
      out_valid   <= valid_d;
      last        <= last_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      frame_count <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = selection;
    valid_d = out_valid;
    last_d  = last;
    busy_d  = busy;
    done_d  = 1'b0;
    count_d = frame_count;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = chan_mask;
          if (first_found) begin
            state_d = ST_SEND;
            sel_d   = first_idx;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = first_last;
          end else begin
            done_d  = 1'b1;
            count_d = frame_count + CNT_W'(1);
          end
        end
      end
      ST_SEND: begin
        // Abort outranks completion: an aborted final handshake is not counted.
        if (abort) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (out_ready) begin
          if (last) begin
            done_d  = 1'b1;
            count_d = frame_count + CNT_W'(1);
            if (continuous && first_found) begin
              mask_d = chan_mask;
              sel_d  = first_idx;
              last_d = first_last;
            end else begin
              state_d = ST_IDLE;
              sel_d   = '0;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
            end
          end else if (adv_found) begin
            sel_d  = adv_idx;
            last_d = adv_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Self-checking bench for output_sequencer: a queue-based frame model predicts
// every output each cycle under directed and randomized stimulus.
module tb_output_sequencer;

  localparam int NP    = 10;
  localparam int SW    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          continuous = 1'b0;
  logic [NP-1:0] chan_mask = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [SW-1:0] selection;
  logic          last;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] frame_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: a frame is the list of enabled packet indices still to be sent.
  int            m_q[$];
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  logic [CW-1:0] m_count = '0;

  logic [23:0] obs;
  assign obs = {out_valid, selection, last, busy, frame_done, frame_count};

  output_sequencer #(.NUM_PACKETS(NP), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .continuous  (continuous),
    .chan_mask   (chan_mask),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .selection   (selection),
    .last        (last),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_vec();
    logic [SW-1:0] s;
    logic          l;
    s = m_busy ? SW'(m_q[0]) : '0;
    l = m_busy && (m_q.size() == 1);
    return {m_busy, s, l, m_busy, m_done, m_count};
  endfunction

  task automatic load_frame(input logic [NP-1:0] m);
    m_q.delete();
    for (int i = 0; i < NP; i++) if (m[i]) m_q.push_back(i);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_count = '0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (!m_busy) begin
      if (start) begin
        if (chan_mask != '0) begin
          load_frame(chan_mask);
          m_busy = 1'b1;
        end else begin
          m_done  = 1'b1;
          m_count = m_count + 1'b1;
        end
      end
    end else if (abort) begin
      m_q.delete();
      m_busy = 1'b0;
    end else if (out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_done  = 1'b1;
        m_count = m_count + 1'b1;
        if (continuous && chan_mask != '0) load_frame(chan_mask);
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    tests_run++;
    if (obs !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got %h expected %h", obs, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_mask();
    int seen[$];
    continuous = 1'b0;
    out_ready  = 1'b1;
    chan_mask  = 10'h3FF;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (out_valid && out_ready) seen.push_back(int'(selection));
      step();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL full_mask c%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    tests_run++;
    if (seen.size() != 10 || seen[0] != 0 || seen[9] != 9 || frame_count !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL full_mask_seq: got %0d packets count %0d expected 10 packets count 1",
               seen.size(), frame_count);
    end
  endtask

  task automatic test_sparse_toggle();
    int seen[$];
    int want[4] = '{0, 2, 5, 9};
    chan_mask = 10'b10_0010_0101;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      out_ready = c[0];
      if (out_valid && out_ready) seen.push_back(int'(selection));
      step();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL sparse c%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    tests_run++;
    if (seen.size() != 4 || seen[0] != want[0] || seen[1] != want[1] ||
        seen[2] != want[2] || seen[3] != want[3]) begin
      tests_failed++;
      $display("[TB] FAIL sparse_seq: got %p expected %p", seen, want);
    end
  endtask

  task automatic test_zero_mask();
    chan_mask = '0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL zero_mask c%0d: got %h expected %h", c, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_continuous();
    chan_mask  = 10'h201;
    continuous = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c == 7) continuous = 1'b0;
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL continuous c%0d: got %h expected %h", c, obs, exp_vec());
      end
      step();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL continuous_stop: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    logic [CW-1:0] cnt_before;
    bit            hit;
    chan_mask = 10'h3FF;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 12 && !hit; c++) begin
      if (m_busy && m_q[0] == 4) hit = 1'b1;
      else step();
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach4: got no index 4 expected index 4");
    end
    cnt_before = m_count;
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (obs !== exp_vec() || frame_count !== cnt_before) begin
      tests_failed++;
      $display("[TB] FAIL abort_mid: got %h expected %h", obs, exp_vec());
    end
    chan_mask = 10'h201;
    start     = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 6 && !hit; c++) begin
      if (m_busy && m_q.size() == 1) hit = 1'b1;
      else step();
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach_last: got no last packet expected last packet");
    end
    cnt_before = m_count;
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (obs !== exp_vec() || frame_count !== cnt_before) begin
        tests_failed++;
        $display("[TB] FAIL abort_last c%0d: got %h expected %h", c, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    chan_mask = 10'h3FF;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (obs !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs, 24'h0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    chan_mask = 10'h0F0;
    start     = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (obs !== exp_vec() || selection !== 4'd4) begin
      tests_failed++;
      $display("[TB] FAIL restart_after_reset: got %h expected %h", obs, exp_vec());
    end
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start      = ($urandom % 4) == 0;
      abort      = ($urandom % 20) == 0;
      continuous = $urandom % 2;
      out_ready  = ($urandom % 3) != 0;
      chan_mask  = (($urandom % 8) == 0) ? '0 : NP'($urandom);
      step();
      tests_run++;
      if (obs !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random c%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_toggle();
    test_zero_mask();
    test_continuous();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/output_sequencer.md
Name: output_sequencer

Overview:
- Parametrised successor to the fixed 10-way output selector. It steps a mux select across NUM_PACKETS coincidence-count packets and feeds them to the downstream transmitter.
- Adds a per-packet enable mask with skipping of disabled packets, a valid/ready handshake toward the transmitter, single-shot or continuous frame modes, abort, and frame status.
- Sits between the count registers (selected by `selection`) and the serial/USB transmit block.

Parameters:
- NUM_PACKETS, 10, number of selectable packets. Legal range 2..64.
- SEL_W, $clog2(NUM_PACKETS), width of `selection`. Derived; must not be overridden.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- start, input, 1: one-cycle request to begin a frame.
- abort, input, 1: synchronous frame abort.
- continuous, input, 1: 1 = auto-restart the frame on completion. Sampled at frame end.
- chan_mask, input, NUM_PACKETS: bit i = 1 means packet i is sent.
- out_ready, input, 1: transmitter can accept the current packet.
- out_valid, output, 1: `selection` names a packet to transmit.
- selection, output, SEL_W: mux select for the packet data path.
- last, output, 1: the current packet is the final enabled packet of the frame.
- busy, output, 1: a frame is in progress.
- frame_done, output, 1: one-cycle pulse when a frame completes.
- frame_count, output, CNT_W: number of completed frames, wraps.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. Outputs: selection = 0, out_valid = 0, last = 0, busy = 0, frame_done = 0, frame_count = 0, mask_q = 0.
- States: IDLE and SEND. All outputs are registered.
- IDLE:
  - On start = 1, latch chan_mask into mask_q.
  - If chan_mask ≠ 0: next cycle go to SEND with selection = lowest set bit index, out_valid = 1, busy = 1.
  - If chan_mask = 0: next cycle pulse frame_done, increment frame_count, stay in IDLE with out_valid = 0.
  - Latency: start at cycle N gives out_valid at N+1.
- SEND, holding rule: out_valid stays 1. While out_ready = 0, selection and last hold stable.
- SEND, advance rule: on out_valid & out_ready, selection moves to the next set bit of mask_q above the current index, in the next cycle. Disabled packets are skipped in zero cycles, with no bubble.
- last = 1 when no set bit of mask_q lies above `selection`.
- Frame end: handshake completes with last = 1. Next cycle:
  - frame_done = 1 for one cycle.
  - frame_count increments modulo 2^CNT_W.
  - If continuous = 1 and chan_mask ≠ 0: re-latch chan_mask, stay in SEND with selection = its lowest set bit, out_valid = 1. This gives back-to-back frames with no idle cycle.
  - Otherwise: go to IDLE, out_valid = 0, busy = 0, selection = 0.
- start while busy: ignored.
- chan_mask changes mid-frame: no effect until the next latch.
- abort = 1 in SEND: next cycle go to IDLE with out_valid = 0, busy = 0, selection = 0. No frame_done pulse, no count increment.
- Priority: abort > frame completion > start. If abort and the last handshake occur in the same cycle, abort wins and the frame is not counted.
- Wrap: `selection` never exceeds NUM_PACKETS-1. Unused bits above NUM_PACKETS in internal vectors are zero.
- rst_n asserted mid-frame: everything returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package ccu_pkg holds the state encoding (ST_IDLE, ST_SEND) and the default NUM_PACKETS = 10 constant.
- One combinational sub-module, first_set_above, parametrised by NUM_PACKETS:
  - Inputs: mask, index, and a "from_zero" flag.
  - Outputs: next_index and found.
- Used twice: once for the frame's first packet and once for advancing.

Test Plan:
- NUM_PACKETS=10, mask 0x3FF, ready held 1, single-shot: start → selection 0..9 on consecutive cycles, last on 9, frame_done pulse one cycle later, frame_count = 1, busy falls.
- Mask 0b1000100101, ready toggling 1/0: selection sequence 0, 2, 5, 9. Each value is held while ready = 0. last only at 9.
- Mask 0, start → no out_valid, frame_done pulse at N+1, frame_count increments.
- continuous = 1, mask 0x201, ready = 1: selection 0, 9, 0, 9 with no gap. frame_done pulses after each 9. Drop continuous → the machine returns to IDLE after the next 9.
- abort asserted while selection = 4 → next cycle out_valid = 0, busy = 0, selection = 0, no frame_done, frame_count unchanged. Abort and final handshake together → frame not counted.
- rst_n pulsed low mid-frame between clock edges → outputs reach reset values before the next edge. A start after release begins cleanly at the lowest enabled packet.
